spi_slave_engine: RTL and testbench

- SPI slave-side transfer engine, the counterpart of the master clock/shift path in the SPI_APB block.
- Receives an external master's serial clock, slave select and MOSI, oversamples them in the pclk domain, and shifts words of 1..32 bits in both directions.
- Presents completed receive words and accepts transmit words through valid/ready handshakes toward the APB register file.
- Shares cpol/cpha/data_len semantics with the master path.

---
 rtl/spi_slave_engine.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_spi_slave_engine.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_engine.sv
// -----------------------------------------------------------------------------
// spi_slave_engine
//
// Slave-side SPI transfer engine. An external master's SCK, slave select and
// MOSI are oversampled in the pclk domain. Words of 1..32 bits are shifted in
// both directions. Completed receive words and new transmit words move through
// valid/ready handshakes toward the APB register file. cpol/cpha/data_len mean
// the same thing here as they do in the master path.
//
// Ports
//   pclk, preset_n        system clock (>= 4x SCK), async active-low reset
//   enable                engine enable; ss_n is ignored while low
//   cpol, cpha            SCK idle level / sample on trailing edge when 1
//   lsb_first, data_len   bit order, word length minus one
//   s_clock, ss_n, mosi   serial inputs from the master (asynchronous)
//   miso, miso_oe         serial output and pad output enable
//   tx_data/valid/ready   transmit holding register handshake
//   rx_data/valid, rx_ack last received word (right-aligned) and its consume
//   transfer_complete     one-cycle pulse per finished word
//   busy                  frame in progress
//   overrun, underrun, frame_error  sticky error flags, cleared by err_clear
// -----------------------------------------------------------------------------
module spi_slave_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [4:0]            data_len,
  input  logic                  s_clock,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  transfer_complete,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_error,
  input  logic                  err_clear
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  state_t state, state_nxt;

  // Synchronizers plus one extra SCK flop for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, ss_s, mosi_s;
  // Set once a deasserted slave select has been seen; a frame already in
  // progress when reset is released must not be joined halfway through.
  logic                   armed;

  // Configuration captured while idle, frozen for the whole frame.
  logic                   cfg_cpol, cfg_cpha, cfg_lsb;
  logic [4:0]             cfg_len;

  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_valid;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [4:0]             bit_cnt;
  logic                   first_pending;     // cpha=1: first leading edge repeats bit 0
  logic                   reload_pending;    // a word ended; next shift edge reloads
  logic                   underrun_pending;  // empty reload seen, flag once clocked
  logic                   word_end;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic start, stop, in_frame, last_bit;
  logic tx_push, tx_reload, load_word;
  logic underrun_set, overrun_set, frame_err_set;

  logic                  ld_lsb, ld_first;
  logic [4:0]            ld_len;
  logic [DATA_WIDTH-1:0] ld_word, ld_aligned, ld_rest, rx_word;

  // Distance between the top of the register and the top bit of a word.
  function automatic int align_shift(input logic [4:0] len);
    return DATA_WIDTH - 1 - int'(len);
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign lead_edge  = cfg_cpol ? sclk_fall : sclk_rise;
  assign trail_edge = cfg_cpol ? sclk_rise : sclk_fall;

  assign in_frame    = (state == ACTIVE) && !stop;
  assign sample_edge = in_frame && (cfg_cpha ? trail_edge : lead_edge);
  assign shift_edge  = in_frame && (cfg_cpha ? lead_edge : trail_edge);
  assign last_bit    = (bit_cnt == cfg_len);

  assign tx_push   = tx_valid && !hold_valid;
  assign tx_reload = shift_edge && reload_pending;
  assign load_word = start || tx_reload;

  // A reload that happens in mode cpha=0 occurs on the edge that returns SCK
  // to idle after a word, even when the master is about to end the frame, so
  // an empty reload there is only flagged once the master clocks a bit of it.
  assign underrun_set  = (load_word && !hold_valid && (start || cfg_cpha)) ||
                         (sample_edge && underrun_pending);
  assign overrun_set   = word_end && rx_valid && !rx_ack;
  assign frame_err_set = stop && (bit_cnt != 5'd0);

  assign busy     = (state == ACTIVE);
  assign miso_oe  = (state == ACTIVE);
  assign tx_ready = !hold_valid;

  // ---------------------------------------------------------------------------
  // Input synchronizers and state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the values from before the edge, independent of statement order.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sclk_sync <= '0;
      // Slave select resets to "selected": the engine only arms after it has
      // really observed ss_n high on the pin.
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
      state     <= IDLE;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], s_clock};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      armed     <= armed | ss_s;
      state     <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s && enable && armed) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s || !enable) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word loaded into the tx shifter. On frame entry the live configuration is
  // used because it is being captured on that same edge. For MSB-first the
  // word is pre-aligned so its top bit sits in the register MSB.
  always_comb begin
    ld_lsb     = (state == IDLE) ? lsb_first : cfg_lsb;
    ld_len     = (state == IDLE) ? data_len : cfg_len;
    ld_word    = hold_valid ? hold_data : '0;
    ld_aligned = ld_word << align_shift(ld_len);
    ld_first   = ld_lsb ? ld_word[0] : ld_aligned[DATA_WIDTH-1];
    ld_rest    = ld_lsb ? (ld_word >> 1) : (ld_aligned << 1);
    // LSB-first words enter at the top and are shifted down; MSB-first words
    // enter at the bottom and stale upper bits are masked off.
    rx_word    = cfg_lsb ? (rx_shift >> align_shift(cfg_len))
                         : (rx_shift & (ONES >> align_shift(cfg_len)));
  end

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cfg_cpol         <= 1'b0;
      cfg_cpha         <= 1'b0;
      cfg_lsb          <= 1'b0;
      cfg_len          <= 5'd0;
      hold_data        <= '0;
      hold_valid       <= 1'b0;
      tx_shift         <= '0;
      miso             <= 1'b0;
      rx_shift         <= '0;
      bit_cnt          <= 5'd0;
      first_pending    <= 1'b0;
      reload_pending   <= 1'b0;
      underrun_pending <= 1'b0;
      word_end         <= 1'b0;
    end else begin
      word_end <= 1'b0;

      if (state == IDLE) begin
        cfg_cpol <= cpol;
        cfg_cpha <= cpha;
        cfg_lsb  <= lsb_first;
        cfg_len  <= data_len;
      end

      hold_valid <= (hold_valid && !load_word) || tx_push;
      if (tx_push) hold_data <= tx_data;

      if (load_word) begin
        tx_shift <= ld_rest;
        miso     <= ld_first;
      end

      if (start) begin
        bit_cnt          <= 5'd0;
        rx_shift         <= '0;
        first_pending    <= 1'b1;
        reload_pending   <= 1'b0;
        underrun_pending <= 1'b0;
      end else if (stop) begin
        miso             <= 1'b0;
        bit_cnt          <= 5'd0;
        first_pending    <= 1'b0;
        reload_pending   <= 1'b0;
        underrun_pending <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift <= cfg_lsb ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                              : {rx_shift[DATA_WIDTH-2:0], mosi_s};
          underrun_pending <= 1'b0;
          if (last_bit) begin
            bit_cnt        <= 5'd0;
            word_end       <= 1'b1;
            reload_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        if (shift_edge) begin
          first_pending <= 1'b0;
          if (reload_pending) begin
            reload_pending   <= 1'b0;
            underrun_pending <= !hold_valid && !cfg_cpha;
          end else if (!(cfg_cpha && first_pending)) begin
            miso     <= cfg_lsb ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
            tx_shift <= cfg_lsb ? (tx_shift >> 1) : (tx_shift << 1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive handshake and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rx_data           <= '0;
      rx_valid          <= 1'b0;
      transfer_complete <= 1'b0;
      overrun           <= 1'b0;
      underrun          <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      transfer_complete <= word_end;
      // An unread word is never overwritten; an ack in the same cycle frees it.
      if (word_end && (!rx_valid || rx_ack)) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      overrun     <= overrun_set   || (overrun     && !err_clear);
      underrun    <= underrun_set  || (underrun    && !err_clear);
      frame_error <= frame_err_set || (frame_error && !err_clear);
    end
  end

endmodule

// File: tb/tb_spi_slave_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_engine
//
// Directed bench for spi_slave_engine. The bench plays the SPI master with
// SCK at pclk/8, drives the register-side handshakes and compares every
// observed value with a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_spi_slave_engine;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        enable = 1'b1;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic [4:0]  data_len = 5'd7;
  logic        s_clock = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        transfer_complete;
  logic        busy;
  logic        overrun;
  logic        underrun;
  logic        frame_error;
  logic        err_clear = 1'b0;

  int checks = 0;
  int errors = 0;
  int tc_count = 0;

  spi_slave_engine #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .pclk              (pclk),
    .preset_n          (preset_n),
    .enable            (enable),
    .cpol              (cpol),
    .cpha              (cpha),
    .lsb_first         (lsb_first),
    .data_len          (data_len),
    .s_clock           (s_clock),
    .ss_n              (ss_n),
    .mosi              (mosi),
    .miso              (miso),
    .miso_oe           (miso_oe),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ack            (rx_ack),
    .transfer_complete (transfer_complete),
    .busy              (busy),
    .overrun           (overrun),
    .underrun          (underrun),
    .frame_error       (frame_error),
    .err_clear         (err_clear)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) if (transfer_complete === 1'b1) tc_count++;

  // Inputs change 2 ns after a rising pclk edge; outputs are read there too.
  task automatic cycles(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb, input logic [4:0] len);
    cpol = pol; cpha = pha; lsb_first = lsb; data_len = len;
    s_clock = pol;
    cycles(6);
  endtask

  task automatic push_tx(input logic [31:0] d);
    int guard;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 100) begin
      cycles(1);
      guard++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_tx_timeout: tx_ready=%b required 1", tx_ready);
    end
    tx_data = d; tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; cycles(1); rx_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1; cycles(1); err_clear = 1'b0;
  endtask

  task automatic begin_frame();
    ss_n = 1'b0;
    cycles(6);
  endtask

  task automatic end_frame();
    cycles(4);
    ss_n = 1'b1;
    cycles(8);
  endtask

  // Master side of one word: drives MOSI, captures MISO on the master's own
  // sample edge, half period = 4 pclk.
  task automatic xfer(input int nbits, input logic [31:0] out_w, output logic [31:0] in_w);
    int idx;
    in_w = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_first ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = out_w[idx];
        cycles(4);
        in_w[idx] = miso;
        s_clock = ~cpol;
        cycles(4);
        s_clock = cpol;
      end else begin
        s_clock = ~cpol;
        mosi = out_w[idx];
        cycles(4);
        in_w[idx] = miso;
        s_clock = cpol;
        cycles(4);
      end
    end
  endtask

  // Packed view: miso, miso_oe, tx_ready, rx_valid, transfer_complete, busy,
  // overrun, underrun, frame_error.
  function automatic logic [8:0] out_bits();
    return {miso, miso_oe, tx_ready, rx_valid, transfer_complete, busy, overrun, underrun, frame_error};
  endfunction

  task automatic test_reset();
    preset_n = 1'b0;
    #23;
    checks++;
    if (out_bits() !== 9'b001000000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", out_bits(), 9'b001000000);
    end
    checks++;
    if (rx_data !== 32'h0) begin
      errors++; $display("FAIL reset_rx_data: got %h expected %h", rx_data, 32'h0);
    end
    @(posedge pclk); #2;
    preset_n = 1'b1;
    cycles(6);
    checks++;
    if (out_bits() !== 9'b001000000) begin
      errors++; $display("FAIL post_reset_outputs: got %b expected %b", out_bits(), 9'b001000000);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] got;
    int base;
    set_mode(1'b0, 1'b0, 1'b0, 5'd7);
    push_tx(32'hA5);
    base = tc_count;
    begin_frame();
    checks++;
    if ({busy, miso_oe, tx_ready, miso} !== 4'b1111) begin
      errors++; $display("FAIL mode0_entry busy/oe/ready/miso: got %b expected %b", {busy, miso_oe, tx_ready, miso}, 4'b1111);
    end
    xfer(8, 32'h3C, got);
    end_frame();
    checks++;
    if (got !== 32'hA5) begin
      errors++; $display("FAIL mode0_miso_stream: got %h expected %h", got, 32'hA5);
    end
    checks++;
    if (rx_data !== 32'h3C || rx_valid !== 1'b1) begin
      errors++; $display("FAIL mode0_rx: got %h/%b expected %h/1", rx_data, rx_valid, 32'h3C);
    end
    checks++;
    if (tc_count - base !== 1) begin
      errors++; $display("FAIL mode0_tc_pulses: got %0d expected 1", tc_count - base);
    end
    checks++;
    if ({overrun, underrun, frame_error, busy} !== 4'b0000) begin
      errors++; $display("FAIL mode0_flags: got %b expected 0000", {overrun, underrun, frame_error, busy});
    end
    pulse_ack();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL mode0_ack: rx_valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got1, got2;
    int base;
    set_mode(1'b1, 1'b1, 1'b1, 5'd15);
    push_tx(32'hCAFE);
    base = tc_count;
    begin_frame();
    push_tx(32'h5AA5);
    xfer(16, 32'h1234, got1);
    checks++;
    if (rx_data !== 32'h1234 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_word1: got %h/%b expected %h/1", rx_data, rx_valid, 32'h1234);
    end
    checks++;
    if ({busy, tx_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_mid busy/tx_ready: got %b expected 10", {busy, tx_ready});
    end
    pulse_ack();
    xfer(16, 32'hBEEF, got2);
    checks++;
    if ({busy, tx_ready} !== 2'b11) begin
      errors++; $display("FAIL b2b_end busy/tx_ready: got %b expected 11", {busy, tx_ready});
    end
    end_frame();
    checks++;
    if (got1 !== 32'hCAFE || got2 !== 32'h5AA5) begin
      errors++; $display("FAIL b2b_miso: got %h,%h expected %h,%h", got1, got2, 32'hCAFE, 32'h5AA5);
    end
    checks++;
    if (rx_data !== 32'hBEEF || rx_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_word2: got %h/%b expected %h/1", rx_data, rx_valid, 32'hBEEF);
    end
    checks++;
    if (tc_count - base !== 2) begin
      errors++; $display("FAIL b2b_tc_pulses: got %0d expected 2", tc_count - base);
    end
    checks++;
    if ({overrun, underrun, frame_error} !== 3'b000) begin
      errors++; $display("FAIL b2b_flags: got %b expected 000", {overrun, underrun, frame_error});
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    logic [31:0] got;
    set_mode(1'b0, 1'b0, 1'b0, 5'd7);
    push_tx(32'h00);
    begin_frame();
    xfer(8, 32'h11, got);
    xfer(8, 32'h22, got);
    end_frame();
    checks++;
    if (rx_data !== 32'h11 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_keep_word: got %h/%b expected %h/1", rx_data, rx_valid, 32'h11);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b expected 1", overrun);
    end
    pulse_clear();
    checks++;
    if ({overrun, underrun} !== 2'b00) begin
      errors++; $display("FAIL overrun_clear: got %b expected 00", {overrun, underrun});
    end
    pulse_ack();
  endtask

  task automatic test_frame_error();
    logic [31:0] got;
    int base;
    set_mode(1'b0, 1'b0, 1'b0, 5'd7);
    push_tx(32'h0F);
    base = tc_count;
    begin_frame();
    xfer(5, 32'h1F, got);
    end_frame();
    checks++;
    if (frame_error !== 1'b1) begin
      errors++; $display("FAIL frame_error_flag: got %b expected 1", frame_error);
    end
    checks++;
    if ({rx_valid, miso_oe, busy} !== 3'b000 || tc_count - base !== 0) begin
      errors++; $display("FAIL frame_error_state: valid/oe/busy=%b tc=%0d expected 000 tc=0", {rx_valid, miso_oe, busy}, tc_count - base);
    end
    pulse_clear();
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL frame_error_clear: got %b expected 0", frame_error);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] got;
    set_mode(1'b0, 1'b0, 1'b0, 5'd7);
    begin_frame();
    xfer(8, 32'h5A, got);
    end_frame();
    checks++;
    if (got !== 32'h00) begin
      errors++; $display("FAIL underrun_miso: got %h expected %h", got, 32'h00);
    end
    checks++;
    if ({underrun, tx_ready} !== 2'b11) begin
      errors++; $display("FAIL underrun_flag/tx_ready: got %b expected 11", {underrun, tx_ready});
    end
    checks++;
    if (rx_data !== 32'h5A) begin
      errors++; $display("FAIL underrun_rx: got %h expected %h", rx_data, 32'h5A);
    end
    pulse_clear();
    pulse_ack();
  endtask

  task automatic test_len_extremes();
    logic [31:0] got;
    set_mode(1'b0, 1'b1, 1'b0, 5'd0);
    push_tx(32'h1);
    begin_frame();
    xfer(1, 32'h1, got);
    end_frame();
    checks++;
    if (rx_data !== 32'h1 || rx_valid !== 1'b1 || got !== 32'h1) begin
      errors++; $display("FAIL len0: rx %h/%b miso %h expected 1/1 1", rx_data, rx_valid, got);
    end
    pulse_ack();
    set_mode(1'b0, 1'b1, 1'b0, 5'd31);
    push_tx(32'h13579BDF);
    begin_frame();
    xfer(32, 32'hDEADBEEF, got);
    end_frame();
    checks++;
    if (rx_data !== 32'hDEADBEEF || rx_valid !== 1'b1) begin
      errors++; $display("FAIL len31_rx: got %h/%b expected %h/1", rx_data, rx_valid, 32'hDEADBEEF);
    end
    checks++;
    if (got !== 32'h13579BDF) begin
      errors++; $display("FAIL len31_miso: got %h expected %h", got, 32'h13579BDF);
    end
    checks++;
    if ({overrun, underrun, frame_error} !== 3'b000) begin
      errors++; $display("FAIL len_extremes_flags: got %b expected 000", {overrun, underrun, frame_error});
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] got;
    int base;
    set_mode(1'b0, 1'b0, 1'b0, 5'd7);
    push_tx(32'hFF);
    base = tc_count;
    begin_frame();
    xfer(3, 32'h07, got);
    preset_n = 1'b0;
    #1;
    checks++;
    if (out_bits() !== 9'b001000000 || rx_data !== 32'h0) begin
      errors++; $display("FAIL midword_reset: got %b/%h expected %b/0", out_bits(), rx_data, 9'b001000000);
    end
    @(posedge pclk); #2;
    preset_n = 1'b1;
    xfer(5, 32'h1F, got);
    checks++;
    if ({busy, miso_oe, rx_valid} !== 3'b000 || tc_count - base !== 0) begin
      errors++; $display("FAIL midword_ignored: busy/oe/valid=%b tc=%0d expected 000 tc=0", {busy, miso_oe, rx_valid}, tc_count - base);
    end
    end_frame();
    begin_frame();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midword_restart: busy=%b expected 1", busy);
    end
    ss_n = 1'b1;
    cycles(8);
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL midword_final: busy/valid=%b expected 00", {busy, rx_valid});
    end
    pulse_clear();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_underrun();
    test_len_extremes();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
